// File: rtl/wide_prefix_add_seq.sv
// Multi-cycle wide adder: sums two WIDTH-bit operands one CHUNK-bit slice per
// cycle, least-significant slice first. Each slice uses a Kogge-Stone style
// generate/propagate prefix network. A registered carry links the slices.
// The result is handed off over a valid/ready handshake.
module wide_prefix_add_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // A partial last slice would silently drop high operand bits, so refuse it.
  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : gWidthCheck
    $error("wide_prefix_add_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDXW-1:0]  r_idx;

  logic [CHUNK-1:0] w_sliceA;
  logic [CHUNK-1:0] w_sliceB;
  logic [CHUNK-1:0] w_sliceSum;
  logic             w_sliceCout;
  logic             w_msbCin;
  logic             w_lastSlice;

  // CHUNK-bit prefix adder. The incoming carry is folded into the bit-0
  // generate, so the group generate at bit i is exactly the carry into bit
  // i+1. Returns {carry into MSB, carry out, sum}.
  function automatic logic [CHUNK+1:0] prefixAdd(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             cin
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] gg;
    logic [CHUNK-1:0] pp;
    logic [CHUNK-1:0] c;
    g    = a & b;
    p    = a ^ b;
    g[0] = g[0] | (p[0] & cin);
    gg   = g;
    pp   = p;
    // Walk bits high-to-low so each level reads the previous level's values.
    for (int d = 1; d < CHUNK; d = d * 2) begin
      for (int i = CHUNK - 1; i >= 1; i--) begin
        if (i >= d) begin
          gg[i] = gg[i] | (pp[i] & gg[i-d]);
          pp[i] = pp[i] & pp[i-d];
        end
      end
    end
    c[0] = cin;
    for (int i = 1; i < CHUNK; i++) begin
      c[i] = gg[i-1];
    end
    return {c[CHUNK-1], gg[CHUNK-1], p ^ c};
  endfunction

  // Select the active slice of each operand and add it with the running carry.
  always_comb begin
    w_sliceA    = r_a[int'(r_idx)*CHUNK +: CHUNK];
    w_sliceB    = r_b[int'(r_idx)*CHUNK +: CHUNK];
    w_lastSlice = (r_idx == IDXW'(NCHUNK - 1));
    {w_msbCin, w_sliceCout, w_sliceSum} = prefixAdd(w_sliceA, w_sliceB, r_carry);
  end

  // State register; reset always wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs; all of them are decoded from the state.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_lastSlice) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands in IDLE, then add one slice per RUN edge. The
  // index returns to 0 after the last slice so it never points past the
  // operands while the block waits in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
          end
        end
        RUN: begin
          r_sum[int'(r_idx)*CHUNK +: CHUNK] <= w_sliceSum;
          r_carry <= w_sliceCout;
          if (w_lastSlice) begin
            r_idx  <= '0;
            r_cout <= w_sliceCout;
            r_ovf  <= w_msbCin ^ w_sliceCout;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum  = r_sum;
  assign out_cout = r_cout;
  assign out_ovf  = r_ovf;

endmodule

// File: doc/wide_prefix_add_seq.md
Name: wide_prefix_add_seq

Overview:
Multi-cycle wide adder that sits directly upstream of the result consumers and drives the 16-bit prefix-adder datapath. It accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake. It adds the operands one CHUNK-bit slice per cycle, least-significant slice first, using a CHUNK-bit prefix (generate/propagate) add with a registered carry between slices. It presents the full sum, carry-out and signed-overflow flag on a valid/ready output.

Parameters:
WIDTH, 64, total operand width; must be an integer multiple of CHUNK (elaboration error otherwise).
CHUNK, 16, slice width added per cycle.
NCHUNK, WIDTH/CHUNK, derived slice count; localparam, not overridable.

Ports:
clk  input  1  sole clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_cin  input  1  carry into bit 0.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  (in_a + in_b + in_cin) mod 2^WIDTH.
out_cout  output  1  carry out of bit WIDTH-1.
out_ovf  output  1  signed overflow, equal to carry-into-MSB XOR carry-out-of-MSB.
busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, slice index=0, carry register=0.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_a, in_b into operand registers and in_cin into the carry register, clear index to 0, go to RUN.
  - Operands change only on this capture.
- RUN:
  - in_ready=0.
  - Each edge computes {c, s} = A[idx] + B[idx] + carry, where A[idx] and B[idx] are slice idx of the operands, with a CHUNK-bit prefix add (g=a&b, p=a^b, carry-in folded into bit 0 generate).
  - Writes s into result slice idx, carry<=c, idx<=idx+1.
  - On the edge that processes idx=NCHUNK-1: out_cout<=c; out_ovf<=(carry into bit CHUNK-1 of that slice) XOR c; go to DONE.
  - Exactly NCHUNK RUN edges, independent of the data: no early termination on zero carry.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf stay stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE and out_valid<=0.
  - out_sum, out_cout and out_ovf keep their last values until the next operation overwrites them.
- Latency: the capture edge is E0; out_valid is first high in the cycle after edge E0+NCHUNK (64-bit default: 4 RUN edges).
- Minimum initiation interval: NCHUNK+2 cycles. in_ready is high only in IDLE; there is no same-cycle accept in DONE.
- in_valid while not in IDLE is ignored; no operand is lost because in_ready=0 signals the stall.
- out_sum partial slices may be observed during RUN but are not valid; the consumer relies on out_valid only.
- Reset mid-operation (RUN or DONE): the operation is discarded, all registers return to their reset values, and no out_valid pulse occurs.
- rst has priority over every handshake on the same edge.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry leaves only via out_cout.
- NCHUNK=1 is legal: a single RUN edge.

Test Plan:
- Full carry ripple: A=64'hFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> out_sum=0, out_cout=1, out_ovf=0; out_valid rises 4 cycles after the accept edge.
- Signed overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_sum=64'h8000_0000_0000_0000, out_cout=0, out_ovf=1. Also A=B=64'h8000_0000_0000_0000 -> sum=0, cout=1, ovf=1.
- Inter-slice carry: A=64'h0000_0000_0000_FFFF, B=1 -> out_sum=64'h0000_0000_0001_0000, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with A=64'h1234_5678_9ABC_DEF0, B=64'h0FED_CBA9_8765_4321 -> sum stays 64'h2222_2222_2222_2211 and in_ready stays 0. A second in_valid is ignored. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst on the 2nd RUN edge -> next cycle FSM=IDLE, out_valid=0, out_sum=0, in_ready=1; a following operation (5+7) yields 12 normally.
- Back-to-back with out_ready tied 1: 3 random operation pairs checked against a reference model; accept edges spaced exactly NCHUNK+2=6 cycles apart.
